// File: rtl/logit_pwl.sv
// Piecewise-linear logit: unsigned Q0.8 probability in, signed Q8.8 logit out, 3-stage elastic pipeline.
// Define LOGIT_SAT_CNT_EN to add the sat_cnt port counting saturated (y = 0) output beats.
module logit_pwl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_y,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_x,
  output logic        out_last
`ifdef LOGIT_SAT_CNT_EN
  ,
  output logic [15:0] sat_cnt
`endif
);

  localparam int DATA_W = 8;
  localparam int COEF_W = 16;

  typedef struct packed {
    logic [DATA_W-2:0] off;
    logic [10:0]       base;
    logic [2:0]        sh;
  } seg_t;

  // Distance of y from one half; the sign of the logit is carried separately.
  function automatic logic [DATA_W-2:0] fold_d(input logic [DATA_W-1:0] y);
    return y[DATA_W-1] ? y[DATA_W-2:0] : (7'd0 - y[DATA_W-2:0]);
  endfunction

  function automatic seg_t seg_sel(input logic [DATA_W-2:0] d);
    seg_t s;
    if (d < 7'd64)       s = '{off: d,          base: 11'h000, sh: 3'd2};
    else if (d < 7'd96)  s = '{off: d - 7'd64,  base: 11'h119, sh: 3'd3};
    else if (d < 7'd112) s = '{off: d - 7'd96,  base: 11'h1F2, sh: 3'd3};
    else if (d < 7'd120) s = '{off: d - 7'd112, base: 11'h2B5, sh: 3'd4};
    else if (d < 7'd124) s = '{off: d - 7'd120, base: 11'h36F, sh: 3'd5};
    else                 s = '{off: d - 7'd124, base: 11'h425, sh: 3'd6};
    return s;
  endfunction

  function automatic logic signed [COEF_W-1:0] clamp_x(input logic signed [COEF_W-1:0] v);
    if (v > 16'sh07FF) return 16'sh07FF;
    if (v < 16'shF800) return 16'shF800;
    return v;
  endfunction

  logic                     en;
  logic                     vld_p0, vld_p1, vld_p2;
  seg_t                     seg_p0;
  logic                     neg_p0, sat_p0, last_p0;
  logic signed [COEF_W-1:0] mag_p1;
  logic                     neg_p1, sat_p1, last_p1;
  logic signed [COEF_W-1:0] x_p2;
  logic                     last_p2;

  assign en        = ~vld_p2 | out_ready;
  assign in_ready  = en;
  assign out_valid = vld_p2;
  assign out_x     = x_p2;
  assign out_last  = last_p2;

  // S1: fold about one half, select segment
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p0  <= 1'b0;
      seg_p0  <= '0;
      neg_p0  <= 1'b0;
      sat_p0  <= 1'b0;
      last_p0 <= 1'b0;
    end else if (en) begin
      vld_p0  <= in_valid;
      seg_p0  <= seg_sel(fold_d(in_y));
      neg_p0  <= ~in_y[DATA_W-1];
      sat_p0  <= (in_y == 8'h00);
      last_p0 <= in_last;
    end
  end

  // S2: magnitude = base + (offset << shift)
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      mag_p1  <= '0;
      neg_p1  <= 1'b0;
      sat_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else if (en) begin
      vld_p1  <= vld_p0;
      mag_p1  <= $signed({5'd0, seg_p0.base}) + $signed({9'd0, seg_p0.off} << seg_p0.sh);
      neg_p1  <= neg_p0;
      sat_p1  <= sat_p0;
      last_p1 <= last_p0;
    end
  end

  // S3: restore sign, force -8.0 for y = 0, clamp to the Q8.8 sigmoid-input range
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p2  <= 1'b0;
      x_p2    <= '0;
      last_p2 <= 1'b0;
    end else if (en) begin
      vld_p2  <= vld_p1;
      x_p2    <= sat_p1 ? 16'shF800 : clamp_x(neg_p1 ? -mag_p1 : mag_p1);
      last_p2 <= last_p1;
    end
  end

`ifdef LOGIT_SAT_CNT_EN
  logic sat_p2;

  // Counts saturated beats as they leave the block; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sat_p2  <= 1'b0;
      sat_cnt <= '0;
    end else begin
      if (en) sat_p2 <= sat_p1;
      if (vld_p2 && out_ready && sat_p2 && (sat_cnt != 16'hFFFF))
        sat_cnt <= sat_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_logit_pwl.sv
// Bench for logit_pwl: directed cases plus randomized traffic against a queue-based reference model.
module tb_logit_pwl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_y = 8'h00;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_x;
  logic        out_last;
`ifdef LOGIT_SAT_CNT_EN
  logic [15:0] sat_cnt;
  int          sat_m = 0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit lat_mode = 1'b0;
  bit rec      = 1'b0;

  typedef struct {
    logic [15:0] x;
    logic        last;
    logic        sat;
    logic [7:0]  y;
    int          acc;
  } beat_t;

  beat_t       q[$];
  logic [15:0] obs_x [256];

  localparam int D0 [6] = '{0, 64, 96, 112, 120, 124};
  localparam int BS [6] = '{'h000, 'h119, 'h1F2, 'h2B5, 'h36F, 'h425};
  localparam int SH [6] = '{2, 3, 3, 4, 5, 6};

  logit_pwl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_y      (in_y),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_last  (out_last)
`ifdef LOGIT_SAT_CNT_EN
    ,
    .sat_cnt   (sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Logit of y/256 from the segment table, in plain integer arithmetic.
  function automatic logic [15:0] ref_x(input logic [7:0] y);
    int yi, d, f, x;
    yi = int'(y);
    if (yi == 0) return 16'hF800;
    d = (yi >= 128) ? yi - 128 : 128 - yi;
    f = 0;
    for (int k = 0; k < 6; k++)
      if (d >= D0[k]) f = BS[k] + ((d - D0[k]) << SH[k]);
    x = (yi >= 128) ? f : -f;
    if (x > 2047) x = 2047;
    if (x < -2048) x = -2048;
    return 16'(x);
  endfunction

  // One clock: drive at the falling edge, then score what the next rising edge will transfer.
  task automatic step(input logic v, input logic [7:0] y, input logic l,
                      input logic ordy, input logic r, input int xe);
    beat_t b;
    @(negedge clk);
    rst = r; in_valid = v; in_y = y; in_last = l; out_ready = ordy;
    #1;
`ifdef LOGIT_SAT_CNT_EN
    if (r) check("sat_cnt", 32'(sat_cnt), 32'(sat_m));
`endif
    if (!r) begin
      q.delete();
`ifdef LOGIT_SAT_CNT_EN
      sat_m = 0;
`endif
    end else begin
      if (out_valid) begin
        if (q.size() == 0) check("orphan", 32'(out_valid), 32'd0);
        else begin
          check("x", 32'(out_x), 32'(q[0].x));
          check("last", 32'(out_last), 32'(q[0].last));
          if (out_ready) begin
            b = q.pop_front();
            if (lat_mode) check("lat", cyc - b.acc, 32'd3);
            if (rec) obs_x[b.y] = out_x;
`ifdef LOGIT_SAT_CNT_EN
            if (b.sat && sat_m != 'hFFFF) sat_m++;
`endif
          end
        end
      end
      if (v && in_ready) begin
        b.x    = (xe >= 0) ? xe[15:0] : ref_x(y);
        b.last = l;
        b.sat  = (y == 8'h00);
        b.y    = y;
        b.acc  = cyc;
        q.push_back(b);
      end
    end
    cyc++;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, -1);
  endtask

  initial begin
    logic [15:0] e;
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, -1);
    check("rst_vld",  32'(out_valid), 32'd0);
    check("rst_x",    32'(out_x),     32'd0);
    check("rst_last", 32'(out_last),  32'd0);
    check("rst_rdy",  32'(in_ready),  32'd1);
`ifdef LOGIT_SAT_CNT_EN
    check("rst_sat",  32'(sat_cnt),   32'd0);
`endif

    lat_mode = 1'b1;
    step(1'b1, 8'h80, 1'b0, 1'b1, 1'b1, 'h0000);
    step(1'b1, 8'hA0, 1'b0, 1'b1, 1'b1, 'h0080);
    step(1'b1, 8'h60, 1'b0, 1'b1, 1'b1, 'hFF80);
    step(1'b1, 8'hC8, 1'b0, 1'b1, 1'b1, 'h0159);
    step(1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 'h04E5);
    step(1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 'hFB1B);
    step(1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 'hF800);
    repeat (4) idle();
    check("dir_drain", q.size(), 32'd0);
`ifdef LOGIT_SAT_CNT_EN
    check("sat_one", 32'(sat_cnt), 32'd1);
`endif

    // Back-pressure with three beats in flight.
    lat_mode = 1'b0;
    repeat (3) step(1'b1, 8'($urandom), 1'($urandom), 1'b1, 1'b1, -1);
    repeat (5) begin
      step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1, -1);
      check("stall_rdy", 32'(in_ready), 32'd0);
    end
    repeat (6) idle();
    check("stall_drain", q.size(), 32'd0);

    // Reset with two beats in flight.
    step(1'b1, 8'h90, 1'b0, 1'b1, 1'b1, -1);
    step(1'b1, 8'h70, 1'b1, 1'b1, 1'b1, -1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, -1);
    idle();
    check("r31_vld", 32'(out_valid), 32'd0);
    check("r31_rdy", 32'(in_ready),  32'd1);
    repeat (5) idle();

    // Full sweep, then symmetry and ordering against the reference table.
    lat_mode = 1'b1;
    rec = 1'b1;
    for (int y = 1; y < 256; y++) step(1'b1, 8'(y), 1'b0, 1'b1, 1'b1, -1);
    repeat (4) idle();
    rec = 1'b0;
    for (int y = 1; y < 256; y++) begin
      e = 16'd0 - ref_x(8'(256 - y));
      check("sym", 32'(obs_x[y]), 32'(e));
    end
    for (int y = 2; y < 256; y++)
      check("mono", 32'($signed(obs_x[y]) >= $signed(obs_x[y-1])),
            32'($signed(ref_x(8'(y))) >= $signed(ref_x(8'(y-1)))));

    // Random traffic with back-pressure and occasional reset.
    lat_mode = 1'b0;
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 299) != 0, -1);
    repeat (8) idle();

    // Random bubbles with a free-running sink: latency must stay fixed.
    lat_mode = 1'b1;
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 2) != 0, 8'($urandom), 1'($urandom), 1'b1, 1'b1, -1);
    lat_mode = 1'b0;

`ifdef LOGIT_SAT_CNT_EN
    for (int i = 0; i < 65536; i++) step(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, -1);
    repeat (5) idle();
    check("sat_hold", 32'(sat_cnt), 32'hFFFF);
`endif

    for (int i = 0; i < 20 && q.size() > 0; i++) idle();
    check("end_q", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/logit_pwl.md
LOGIT_PWL -- requirements
Module: logit_pwl

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: rst  input  1  synchronous, active-low reset.
REQ-003 SHALL have port: in_valid  input  1  input beat present.
REQ-004 SHALL have port: in_ready  output  1  block accepts input beat this cycle.
REQ-005 SHALL have port: in_y  input  8  probability, unsigned Q0.8 (y/256).
REQ-006 SHALL have port: in_last  input  1  end-of-frame sideband, passed through.
REQ-007 SHALL have port: out_valid  output  1  output beat present.
REQ-008 SHALL have port: out_ready  input  1  downstream accepts output beat.
REQ-009 SHALL have port: out_x  output  16  logit(y), two's-complement Q8.8 (the sigmoid-input format).
REQ-010 SHALL have port: out_last  output  1  in_last of the same beat.
REQ-011 SHALL have port (LOGIT_SAT_CNT_EN only): sat_cnt  output  16  count of saturated outputs.

Function
REQ-012 Input beat SHALL be accepted when in_valid and in_ready are both 1; output beat SHALL be transferred when out_valid and out_ready are both 1.
REQ-013 Pipeline SHALL be 3 register stages (S1: fold + segment select; S2: shift-add; S3: sign restore + saturate) with one valid bit per stage.
REQ-014 Global advance enable SHALL be en = ~out_valid | out_ready; in_ready SHALL equal en; all stages SHALL hold when en = 0.
REQ-015 Latency SHALL be exactly 3 cycles from acceptance to out_valid with out_ready held 1; throughput 1 beat/cycle; bubbles SHALL NOT be collapsed.
REQ-016 Beats SHALL never be dropped, duplicated or reordered; out_x and out_last SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-017 Fold: y >= 0x80 -> d = y - 0x80, neg = 0; 0x01 <= y <= 0x7F -> d = 0x80 - y, neg = 1; y = 0x00 -> sat = 1.
REQ-018 Magnitude f(d) = base + ((d - d0) << s) per segment (d range: d0, base, s): 0-63: 0, 0x000, 2; 64-95: 64, 0x119, 3; 96-111: 96, 0x1F2, 3; 112-119: 112, 0x2B5, 4; 120-123: 120, 0x36F, 5; 124-127: 124, 0x425, 6.
REQ-019 out_x SHALL be f(d) if neg = 0 and -f(d) (16-bit two's complement) if neg = 1; sat = 1 SHALL force out_x = 0xF800 (-8.0).
REQ-020 Arithmetic SHALL be carried out at 16 bits with no overflow (max |f| = 0x4E5); the result SHALL be clamped to 0xF800..0x07FF.
REQ-021 When sat and a new acceptance occur in the same cycle, both SHALL take effect independently; the pipeline SHALL carry the sat flag alongside the data.

Reset
REQ-022 When rst = 0 at a clock edge, all stage valid bits SHALL clear and all data, last and sat registers SHALL clear to 0.
REQ-023 During reset, out_valid SHALL be 0, out_x 0x0000, out_last 0, and sat_cnt 0x0000; in_ready SHALL be 1.
REQ-024 Reset asserted mid-stream SHALL discard all in-flight beats; no beat accepted before reset SHALL appear afterward.

Configuration
REQ-025 Macro LOGIT_SAT_CNT_EN defined: sat_cnt SHALL increment by 1 on each transferred output beat whose sat flag is 1, and SHALL hold at 0xFFFF.
REQ-026 Macro LOGIT_SAT_CNT_EN undefined: the sat_cnt port and the counter logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-027 in_y = 0x80, 0xA0, 0x60 on consecutive cycles with out_ready = 1 -> out_x = 0x0000, 0x0080, 0xFF80 on cycles 3, 4 and 5 after the first acceptance.
REQ-028 in_y = 0xC8, 0xFF, 0x01 -> out_x = 0x0159, 0x04E5, 0xFB1B.
REQ-029 in_y = 0x00 with in_last = 1 -> out_x = 0xF800, out_last = 1, sat_cnt 0 -> 1 (LOGIT_SAT_CNT_EN); 65 536 saturated beats -> sat_cnt holds at 0xFFFF.
REQ-030 3 beats in flight, then out_ready = 0 for 5 cycles -> in_ready = 0 and out_x stable; on release, all 3 beats are delivered in order with no loss.
REQ-031 rst = 0 for 1 cycle with 2 beats in flight -> the next cycle has out_valid = 0 and in_ready = 1; neither discarded beat ever appears.
REQ-032 Sweep in_y 0x01-0xFF -> out_x(y) = -out_x(0x100 - y), and out_x is monotonic non-decreasing in y.
